// File: rtl/kplic_pkg.sv
// rtl/kplic_pkg.sv - shared register offsets, sizes and gateway encodings for kplic
package kplic_pkg;

  localparam int KPLIC_SRC_NUM = 8;
  localparam int KPLIC_PRIO_W  = 3;

  localparam logic [11:0] KPLIC_PRIO_BASE = 12'h000;
  localparam logic [11:0] KPLIC_PEND_OFS  = 12'h080;
  localparam logic [11:0] KPLIC_EN_OFS    = 12'h100;
  localparam logic [11:0] KPLIC_THR_OFS   = 12'h200;
  localparam logic [11:0] KPLIC_CLAIM_OFS = 12'h204;

  typedef enum logic [1:0] {
    GW_IDLE    = 2'd0,
    GW_PENDING = 2'd1,
    GW_CLAIMED = 2'd2
  } gw_state_e;

  // Byte address of the priority register for source ID id.
  function automatic logic [11:0] prio_addr(input int id);
    return KPLIC_PRIO_BASE + 12'(4 * id);
  endfunction

endpackage

// File: rtl/kplic_gateway.sv
// rtl/kplic_gateway.sv - per-source synchronizer and IDLE/PENDING/CLAIMED gateway
module kplic_gateway
  import kplic_pkg::*;
(
  input  logic cpu_clk,
  input  logic cpu_rstn,
  input  logic src_irq,
  input  logic claim,
  input  logic complete,
  output logic pending
);

  logic      sync1_q, sync1_d;
  logic      sync2_q, sync2_d;
  gw_state_e state_q, state_d;

  // Synchronizer shift and gateway next state; a claimed source ignores its level until completed.
  always_comb begin
    sync1_d = src_irq;
    sync2_d = sync1_q;
    state_d = state_q;
    case (state_q)
      GW_IDLE:    if (sync2_q)  state_d = GW_PENDING;
      GW_PENDING: if (claim)    state_d = GW_CLAIMED;
      GW_CLAIMED: if (complete) state_d = GW_IDLE;
      default:                  state_d = GW_IDLE;
    endcase
  end

  // State registers; reset drops every gateway, claimed ones included, back to IDLE.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= GW_IDLE;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
    end
  end

  assign pending = (state_q == GW_PENDING);

endmodule

// File: rtl/kplic.sv
// rtl/kplic.sv - platform interrupt controller: registers, arbiter and claim/complete bus
module kplic
  import kplic_pkg::*;
#(
  parameter int SRC_NUM = KPLIC_SRC_NUM,
  parameter int PRIO_W  = KPLIC_PRIO_W
) (
  input  logic               cpu_clk,
  input  logic               cpu_rstn,
  input  logic [SRC_NUM-1:0] src_irq,
  input  logic               kplic_sel,
  input  logic               kplic_wr,
  input  logic [11:0]        kplic_addr,
  input  logic [31:0]        kplic_wdata,
  output logic [31:0]        kplic_rdata,
  output logic               kplic_rdy,
  output logic               kplic_int
);

  localparam int ID_W = $clog2(SRC_NUM + 1);

  logic [SRC_NUM:1][PRIO_W-1:0] prio_q, prio_d;
  logic [SRC_NUM:1]             en_q, en_d;
  logic [PRIO_W-1:0]            thr_q, thr_d;
  logic [31:0]                  rdata_q, rdata_d;
  logic                         rdy_q, rdy_d;
  logic                         int_q, int_d;

  logic [SRC_NUM:1]  pend_vec, claim_vec, cmpl_vec;
  logic [ID_W-1:0]   max_id;
  logic [PRIO_W-1:0] best_prio;
  logic              rd_en, wr_en, claim_hit;

  assign rd_en     = kplic_sel & ~kplic_wr;
  assign wr_en     = kplic_sel &  kplic_wr;
  assign claim_hit = (kplic_addr == KPLIC_CLAIM_OFS);

  genvar g;
  generate
    for (g = 1; g <= SRC_NUM; g++) begin : g_gw
      kplic_gateway u_gw (
        .cpu_clk  (cpu_clk),
        .cpu_rstn (cpu_rstn),
        .src_irq  (src_irq[g-1]),
        .claim    (claim_vec[g]),
        .complete (cmpl_vec[g]),
        .pending  (pend_vec[g])
      );
    end
  endgenerate

  // Arbiter: strict '>' while scanning upward keeps the lowest ID on a priority tie.
  always_comb begin
    best_prio = '0;
    max_id    = '0;
    for (int i = 1; i <= SRC_NUM; i++) begin
      if (pend_vec[i] && en_q[i] && (prio_q[i] > thr_q) && (prio_q[i] > best_prio)) begin
        best_prio = prio_q[i];
        max_id    = ID_W'(i);
      end
    end
  end

  // Claim moves the current winner to CLAIMED; complete releases only the ID written.
  always_comb begin
    claim_vec = '0;
    cmpl_vec  = '0;
    for (int i = 1; i <= SRC_NUM; i++) begin
      claim_vec[i] = rd_en && claim_hit && (max_id == ID_W'(i));
      cmpl_vec[i]  = wr_en && claim_hit && (kplic_wdata == 32'(i));
    end
  end

  // Register writes and read mux; unmapped reads return 0 and rdy pulses for every access.
  always_comb begin
    prio_d  = prio_q;
    en_d    = en_q;
    thr_d   = thr_q;
    rdata_d = '0;
    rdy_d   = kplic_sel;
    int_d   = (max_id != '0);
    for (int i = 1; i <= SRC_NUM; i++) begin
      if (kplic_addr == prio_addr(i)) begin
        if (wr_en) prio_d[i] = kplic_wdata[PRIO_W-1:0];
        if (rd_en) rdata_d   = 32'(prio_q[i]);
      end
    end
    if (kplic_addr == KPLIC_PEND_OFS && rd_en) rdata_d = 32'({pend_vec, 1'b0});
    if (kplic_addr == KPLIC_EN_OFS) begin
      if (wr_en) en_d    = kplic_wdata[SRC_NUM:1];
      if (rd_en) rdata_d = 32'({en_q, 1'b0});
    end
    if (kplic_addr == KPLIC_THR_OFS) begin
      if (wr_en) thr_d   = kplic_wdata[PRIO_W-1:0];
      if (rd_en) rdata_d = 32'(thr_q);
    end
    if (claim_hit && rd_en) rdata_d = 32'(max_id);
  end

  // Register state and registered bus/interrupt outputs.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      prio_q  <= '0;
      en_q    <= '0;
      thr_q   <= '0;
      rdata_q <= '0;
      rdy_q   <= 1'b0;
      int_q   <= 1'b0;
    end else begin
      prio_q  <= prio_d;
      en_q    <= en_d;
      thr_q   <= thr_d;
      rdata_q <= rdata_d;
      rdy_q   <= rdy_d;
      int_q   <= int_d;
    end
  end

  assign kplic_rdata = rdata_q;
  assign kplic_rdy   = rdy_q;
  assign kplic_int   = int_q;

endmodule

// File: tb/tb_kplic.sv
// tb/tb_kplic.sv - scoreboard bench for kplic register, claim/complete and reset behaviour
module tb_kplic;
  import kplic_pkg::*;

  logic        cpu_clk = 1'b0;
  logic        cpu_rstn = 1'b0;
  logic [7:0]  src_irq = '0;
  logic        kplic_sel = 1'b0;
  logic        kplic_wr = 1'b0;
  logic [11:0] kplic_addr = '0;
  logic [31:0] kplic_wdata = '0;
  logic [31:0] kplic_rdata;
  logic        kplic_rdy;
  logic        kplic_int;

  typedef struct {
    string       tag;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   acc_cnt = 0;
  int   rdy_cnt = 0;

  kplic dut (
    .cpu_clk     (cpu_clk),
    .cpu_rstn    (cpu_rstn),
    .src_irq     (src_irq),
    .kplic_sel   (kplic_sel),
    .kplic_wr    (kplic_wr),
    .kplic_addr  (kplic_addr),
    .kplic_wdata (kplic_wdata),
    .kplic_rdata (kplic_rdata),
    .kplic_rdy   (kplic_rdy),
    .kplic_int   (kplic_int)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Every access expects exactly one rdy pulse; its rdata is checked against the queued value.
  always @(negedge cpu_clk) begin
    if (cpu_rstn && kplic_rdy) begin
      exp_t e;
      rdy_cnt++;
      if (exp_q.size() == 0) begin
        chk("rdy_without_access", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk(e.tag, kplic_rdata, e.data);
      end
    end
  end

  task automatic bus_acc(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp, input string tag);
    exp_t e;
    @(negedge cpu_clk);
    kplic_sel   = 1'b1;
    kplic_wr    = wr;
    kplic_addr  = addr;
    kplic_wdata = wdata;
    e.tag  = tag;
    e.data = exp;
    exp_q.push_back(e);
    acc_cnt++;
    @(negedge cpu_clk);
    kplic_sel   = 1'b0;
    kplic_wr    = 1'b0;
    kplic_wdata = '0;
  endtask

  task automatic bus_rd(input logic [11:0] addr, input logic [31:0] exp, input string tag);
    bus_acc(1'b0, addr, 32'd0, exp, tag);
  endtask

  task automatic bus_wr(input logic [11:0] addr, input logic [31:0] wdata);
    bus_acc(1'b1, addr, wdata, 32'd0, "wr_rdata");
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge cpu_clk);
  endtask

  task automatic read_all_zero(input string pfx);
    for (int i = 0; i <= 8; i++) bus_rd(prio_addr(i), 32'd0, {pfx, "_prio"});
    bus_rd(KPLIC_PEND_OFS, 32'd0, {pfx, "_pend"});
    bus_rd(KPLIC_EN_OFS, 32'd0, {pfx, "_en"});
    bus_rd(KPLIC_THR_OFS, 32'd0, {pfx, "_thr"});
    bus_rd(KPLIC_CLAIM_OFS, 32'd0, {pfx, "_claim"});
    bus_rd(12'h300, 32'd0, {pfx, "_unmapped"});
  endtask

  initial begin
    #1;
    chk("rst_int", {31'd0, kplic_int}, 32'd0);
    chk("rst_rdy", {31'd0, kplic_rdy}, 32'd0);
    chk("rst_rdata", kplic_rdata, 32'd0);
    idle(2);
    cpu_rstn = 1'b1;
    read_all_zero("reset");
    chk("reset_int_idle", {31'd0, kplic_int}, 32'd0);

    // Single source latency, claim and interrupt drop.
    bus_wr(prio_addr(3), 32'd2);
    bus_wr(KPLIC_EN_OFS, 32'h08);
    bus_wr(KPLIC_THR_OFS, 32'd0);
    bus_wr(prio_addr(0), 32'd7);
    bus_rd(prio_addr(0), 32'd0, "prio0_hardwired");
    bus_rd(prio_addr(3), 32'd2, "prio3_rd");
    bus_rd(KPLIC_EN_OFS, 32'h08, "en_rd");
    src_irq[2] = 1'b1;
    repeat (3) @(posedge cpu_clk);
    #1 chk("lat_edge3_int", {31'd0, kplic_int}, 32'd0);
    @(posedge cpu_clk);
    #1 chk("lat_edge4_int", {31'd0, kplic_int}, 32'd1);
    bus_rd(KPLIC_CLAIM_OFS, 32'd3, "claim_single");
    chk("int_on_claim_edge", {31'd0, kplic_int}, 32'd1);
    @(posedge cpu_clk);
    #1 chk("int_after_claim", {31'd0, kplic_int}, 32'd0);
    bus_rd(KPLIC_PEND_OFS, 32'd0, "pend_after_claim");
    src_irq[2] = 1'b0;
    idle(3);
    bus_wr(KPLIC_CLAIM_OFS, 32'd3);
    idle(3);
    bus_rd(KPLIC_PEND_OFS, 32'd0, "pend_after_release");

    // Tie break and priority change with re-pending sources.
    bus_wr(prio_addr(2), 32'd4);
    bus_wr(prio_addr(5), 32'd4);
    bus_wr(KPLIC_EN_OFS, 32'h24);
    src_irq[1] = 1'b1;
    src_irq[4] = 1'b1;
    idle(4);
    bus_rd(KPLIC_PEND_OFS, 32'h24, "pend_two");
    bus_rd(KPLIC_CLAIM_OFS, 32'd2, "claim_tie_low_id");
    bus_rd(KPLIC_CLAIM_OFS, 32'd5, "claim_second");
    bus_rd(KPLIC_CLAIM_OFS, 32'd0, "claim_none");
    bus_wr(KPLIC_CLAIM_OFS, 32'd2);
    bus_wr(KPLIC_CLAIM_OFS, 32'd5);
    idle(2);
    bus_wr(prio_addr(5), 32'd5);
    bus_rd(KPLIC_CLAIM_OFS, 32'd5, "claim_higher_prio");
    bus_rd(KPLIC_CLAIM_OFS, 32'd2, "claim_remaining");
    src_irq[1] = 1'b0;
    src_irq[4] = 1'b0;
    idle(3);
    bus_wr(KPLIC_CLAIM_OFS, 32'd5);
    bus_wr(KPLIC_CLAIM_OFS, 32'd2);
    idle(3);
    bus_rd(KPLIC_PEND_OFS, 32'd0, "pend_cleared");

    // Threshold masking, then lowering the threshold.
    bus_wr(prio_addr(3), 32'd4);
    bus_wr(KPLIC_THR_OFS, 32'd4);
    bus_wr(KPLIC_EN_OFS, 32'h08);
    bus_rd(KPLIC_THR_OFS, 32'd4, "thr_rd");
    src_irq[2] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge cpu_clk);
      chk("thr_mask_int", {31'd0, kplic_int}, 32'd0);
    end
    bus_rd(KPLIC_PEND_OFS, 32'h08, "pend_masked");
    bus_wr(KPLIC_THR_OFS, 32'd3);
    chk("thr_write_edge_int", {31'd0, kplic_int}, 32'd0);
    @(posedge cpu_clk);
    #1 chk("thr_next_edge_int", {31'd0, kplic_int}, 32'd1);
    bus_rd(KPLIC_CLAIM_OFS, 32'd3, "claim_after_thr");

    // Source held high while claimed; bogus completes are ignored.
    idle(5);
    bus_rd(KPLIC_PEND_OFS, 32'd0, "pend_held_claimed");
    chk("int_held_claimed", {31'd0, kplic_int}, 32'd0);
    bus_wr(KPLIC_CLAIM_OFS, 32'd5);
    bus_wr(KPLIC_CLAIM_OFS, 32'd0);
    bus_wr(KPLIC_CLAIM_OFS, 32'd9);
    bus_wr(KPLIC_CLAIM_OFS, 32'h103);
    idle(2);
    bus_rd(KPLIC_PEND_OFS, 32'd0, "pend_bad_complete");
    chk("int_bad_complete", {31'd0, kplic_int}, 32'd0);
    bus_wr(KPLIC_CLAIM_OFS, 32'd3);
    idle(1);
    bus_rd(KPLIC_PEND_OFS, 32'h08, "pend_after_complete");
    chk("int_after_complete", {31'd0, kplic_int}, 32'd1);
    bus_rd(KPLIC_CLAIM_OFS, 32'd3, "claim_again");

    // Reset while ID 3 is claimed.
    src_irq = '0;
    idle(3);
    #2 cpu_rstn = 1'b0;
    #1;
    chk("mid_rst_int", {31'd0, kplic_int}, 32'd0);
    chk("mid_rst_rdy", {31'd0, kplic_rdy}, 32'd0);
    chk("mid_rst_rdata", kplic_rdata, 32'd0);
    idle(2);
    cpu_rstn = 1'b1;
    read_all_zero("post_rst");
    chk("post_rst_int", {31'd0, kplic_int}, 32'd0);

    idle(2);
    chk("rdy_count", 32'(rdy_cnt), 32'(acc_cnt));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
